// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - packs popped async-FIFO entries into wide output words
//
// Read-side consumer for the async FIFO, running in the read clock domain.
// It pops DATA_WIDTH entries and packs PACK_NUM of them into one registered
// word. Lanes are little-endian: entry k of a word lands in lane k.
//
// Optional feature: define FIFO_RD_FLUSH_EN to emit a partial word after
// TIMEOUT_CYC idle cycles. Without it, a partial word waits indefinitely.
//
// Ports:
//   rd_clk         read-domain clock
//   rd_rstn        asynchronous active-low reset
//   fifo_rd_ready  pop request to the FIFO
//   fifo_rd_valid  a pop happened this cycle
//   fifo_rd_data   FIFO head data, meaningful when fifo_rd_valid=1
//   out_valid      packed word valid
//   out_ready      downstream accepts the packed word
//   out_data       packed word, lane 0 in the low bits
//   out_bytes      number of valid lanes in out_data
module fifo_rd_packer #(
  parameter int DATA_WIDTH  = 8,
  parameter int PACK_NUM    = 4,
  parameter int CNT_WIDTH   = 2,
  parameter int TIMEOUT_CYC = 16,
  parameter int TMR_WIDTH   = 5
) (
  input  logic                           rd_clk,
  input  logic                           rd_rstn,
  output logic                           fifo_rd_ready,
  input  logic                           fifo_rd_valid,
  input  logic [DATA_WIDTH-1:0]          fifo_rd_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [PACK_NUM*DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH:0]             out_bytes
);

  localparam logic [CNT_WIDTH-1:0] LAST_LANE  = CNT_WIDTH'(PACK_NUM - 1);
  localparam logic [CNT_WIDTH:0]   PACK_BYTES = (CNT_WIDTH + 1)'(PACK_NUM);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic [CNT_WIDTH-1:0]           cnt_q, cnt_d;
  logic [PACK_NUM*DATA_WIDTH-1:0] buf_q, buf_d;
  logic                           out_valid_q, out_valid_d;
  logic [PACK_NUM*DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_WIDTH:0]             out_bytes_q, out_bytes_d;
  logic                           pop;
  logic [PACK_NUM*DATA_WIDTH-1:0] buf_w;

`ifdef FIFO_RD_FLUSH_EN
  localparam logic [TMR_WIDTH-1:0] TMO = TMR_WIDTH'(TIMEOUT_CYC);
  logic [TMR_WIDTH-1:0] tmr_q, tmr_d;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_bytes = out_bytes_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_bytes_d = out_bytes_q;

    // The completing pop is only allowed when the output slot is free or
    // being drained this cycle, so an unaccepted word is never overwritten.
    fifo_rd_ready = (state_q != FLUSH) &&
                    ((cnt_q != LAST_LANE) || !out_valid_q || out_ready);
    pop = fifo_rd_valid && fifo_rd_ready;

    // Buffer with the current entry dropped into lane cnt_q.
    buf_w = buf_q;
    for (int i = 0; i < PACK_NUM; i++) begin
      if (cnt_q == CNT_WIDTH'(i)) begin
        buf_w[i*DATA_WIDTH +: DATA_WIDTH] = fifo_rd_data;
      end
    end

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (state_q == FLUSH) begin
      out_data_d  = buf_q;
      out_bytes_d = {1'b0, cnt_q};
      out_valid_d = 1'b1;
      cnt_d       = '0;
      buf_d       = '0;
      state_d     = IDLE;
    end else if (pop) begin
      if (cnt_q == LAST_LANE) begin
        // A load in the same cycle as an accept simply replaces the word.
        out_data_d  = buf_w;
        out_bytes_d = PACK_BYTES;
        out_valid_d = 1'b1;
        cnt_d       = '0;
        buf_d       = '0;
        state_d     = IDLE;
      end else begin
        buf_d   = buf_w;
        cnt_d   = cnt_q + 1'b1;
        state_d = FILL;
      end
    end

`ifdef FIFO_RD_FLUSH_EN
    tmr_d = tmr_q;
    if ((state_q == FLUSH) || pop || (cnt_q == '0)) begin
      tmr_d = '0;
    end else if (tmr_q != TMO) begin
      tmr_d = tmr_q + 1'b1;
    end
    // Only start a flush on a cycle without a pop, so the buffer being
    // flushed is exactly what is registered when FLUSH is entered.
    if ((state_q != FLUSH) && !pop && (tmr_q == TMO) &&
        (!out_valid_q || out_ready)) begin
      state_d = FLUSH;
    end
`endif
  end

  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      buf_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_bytes_q <= '0;
`ifdef FIFO_RD_FLUSH_EN
      tmr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_bytes_q <= out_bytes_d;
`ifdef FIFO_RD_FLUSH_EN
      tmr_q       <= tmr_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb/tb_fifo_rd_packer.sv - directed self-checking bench for fifo_rd_packer
module tb_fifo_rd_packer;

  logic        rd_clk;
  logic        rd_rstn;
  logic        fifo_rd_ready;
  logic        fifo_rd_valid;
  logic [7:0]  fifo_rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;

  int pass_cnt  = 0;
  int total_cnt = 0;

  fifo_rd_packer #(
    .DATA_WIDTH (8),
    .PACK_NUM   (4),
    .CNT_WIDTH  (2),
    .TIMEOUT_CYC(16),
    .TMR_WIDTH  (5)
  ) dut (
    .rd_clk       (rd_clk),
    .rd_rstn      (rd_rstn),
    .fifo_rd_ready(fifo_rd_ready),
    .fifo_rd_valid(fifo_rd_valid),
    .fifo_rd_data (fifo_rd_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_bytes    (out_bytes)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  // One pop: the FIFO only reports a pop when the packer is ready.
  task automatic pop(input logic [7:0] d);
    fifo_rd_valid = fifo_rd_ready;
    fifo_rd_data  = d;
    tick();
    fifo_rd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rd_rstn       = 1'b0;
    fifo_rd_valid = 1'b0;
    fifo_rd_data  = 8'h00;
    out_ready     = 1'b0;
    repeat (2) tick();
    #2 rd_rstn = 1'b1;
    tick();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_bytes !== 3'd0) $display("FAIL reset_bytes: got %0d expected 0", out_bytes); else pass_cnt++;
    total_cnt++; if (out_data !== 32'h0) $display("FAIL reset_data: got %h expected 00000000", out_data); else pass_cnt++;
    total_cnt++; if (fifo_rd_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", fifo_rd_ready); else pass_cnt++;
    total_cnt++; if (dut.cnt_q !== 2'd0) $display("FAIL reset_cnt: got %0d expected 0", dut.cnt_q); else pass_cnt++;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    pop(8'h11); pop(8'h22); pop(8'h33);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid: got %b expected 0", out_valid); else pass_cnt++;
    pop(8'h44);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL basic_valid: got %b expected 1", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 32'h44332211) $display("FAIL basic_data: got %h expected 44332211", out_data); else pass_cnt++;
    total_cnt++; if (out_bytes !== 3'd4) $display("FAIL basic_bytes: got %0d expected 4", out_bytes); else pass_cnt++;
    tick();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_one_cycle: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 32'h44332211) $display("FAIL basic_data_kept: got %h expected 44332211", out_data); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int idx = 0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (fifo_rd_ready && idx < 8) begin
        fifo_rd_valid = 1'b1;
        fifo_rd_data  = 8'(idx + 1);
      end else begin
        fifo_rd_valid = 1'b0;
      end
      tick();
      if (fifo_rd_valid) idx++;
    end
    fifo_rd_valid = 1'b0;
    total_cnt++; if (idx !== 7) $display("FAIL bp_pop_count: got %0d expected 7", idx); else pass_cnt++;
    total_cnt++; if (fifo_rd_ready !== 1'b0) $display("FAIL bp_ready_low: got %b expected 0", fifo_rd_ready); else pass_cnt++;
    repeat (3) tick();
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid: got %b expected 1", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 32'h04030201) $display("FAIL bp_hold_data: got %h expected 04030201", out_data); else pass_cnt++;
    out_ready = 1'b1;
    #1;
    total_cnt++; if (fifo_rd_ready !== 1'b1) $display("FAIL bp_ready_release: got %b expected 1", fifo_rd_ready); else pass_cnt++;
    pop(8'h08);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL b2b_valid_no_gap: got %b expected 1", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 32'h08070605) $display("FAIL b2b_data: got %h expected 08070605", out_data); else pass_cnt++;
    total_cnt++; if (out_bytes !== 3'd4) $display("FAIL b2b_bytes: got %0d expected 4", out_bytes); else pass_cnt++;
    tick();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_drain: got %b expected 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int words = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total_cnt++; if (fifo_rd_ready !== 1'b1) $display("FAIL stream_ready_%0d: got %b expected 1", i, fifo_rd_ready); else pass_cnt++;
      pop(8'(8'h10 + i));
      if (out_valid) words++;
      if (i == 3) begin
        total_cnt++; if (out_data !== 32'h13121110) $display("FAIL stream_word0: got %h expected 13121110", out_data); else pass_cnt++;
      end
    end
    total_cnt++; if (out_data !== 32'h17161514) $display("FAIL stream_word1: got %h expected 17161514", out_data); else pass_cnt++;
    total_cnt++; if (words !== 2) $display("FAIL stream_word_count: got %0d expected 2", words); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    pop(8'hC1); pop(8'hC2); pop(8'hC3); pop(8'hC4);
    pop(8'hC5); pop(8'hC6);
    #2 rd_rstn = 1'b0;
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 32'h0) $display("FAIL rstmid_data: got %h expected 00000000", out_data); else pass_cnt++;
    total_cnt++; if (out_bytes !== 3'd0) $display("FAIL rstmid_bytes: got %0d expected 0", out_bytes); else pass_cnt++;
    total_cnt++; if (dut.cnt_q !== 2'd0) $display("FAIL rstmid_cnt: got %0d expected 0", dut.cnt_q); else pass_cnt++;
    tick();
    #2 rd_rstn = 1'b1;
    out_ready = 1'b1;
    tick();
    pop(8'hB1); pop(8'hB2); pop(8'hB3); pop(8'hB4);
    total_cnt++; if (out_data !== 32'hB4B3B2B1) $display("FAIL rstmid_fresh_word: got %h expected B4B3B2B1", out_data); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL rstmid_fresh_valid: got %b expected 1", out_valid); else pass_cnt++;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    pop(8'hAA); pop(8'hBB);
`ifdef FIFO_RD_FLUSH_EN
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 17) begin
        total_cnt++; if (fifo_rd_ready !== 1'b0) $display("FAIL flush_ready: got %b expected 0", fifo_rd_ready); else pass_cnt++;
      end
    end
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL flush_valid: got %b expected 1", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 32'h0000BBAA) $display("FAIL flush_data: got %h expected 0000BBAA", out_data); else pass_cnt++;
    total_cnt++; if (out_bytes !== 3'd2) $display("FAIL flush_bytes: got %0d expected 2", out_bytes); else pass_cnt++;
    pop(8'hCC); pop(8'hDD); pop(8'hEE); pop(8'hFF);
    total_cnt++; if (out_data !== 32'hFFEEDDCC) $display("FAIL flush_next_word: got %h expected FFEEDDCC", out_data); else pass_cnt++;
`else
    begin
      int seen = 0;
      for (int k = 0; k < 40; k++) begin
        tick();
        if (out_valid) seen++;
      end
      total_cnt++; if (seen !== 0) $display("FAIL noflush_quiet: got %0d valid cycles expected 0", seen); else pass_cnt++;
      total_cnt++; if (dut.cnt_q !== 2'd2) $display("FAIL noflush_cnt: got %0d expected 2", dut.cnt_q); else pass_cnt++;
    end
    pop(8'hCC); pop(8'hDD);
    total_cnt++; if (out_data !== 32'hDDCCBBAA) $display("FAIL noflush_word: got %h expected DDCCBBAA", out_data); else pass_cnt++;
    total_cnt++; if (out_bytes !== 3'd4) $display("FAIL noflush_bytes: got %0d expected 4", out_bytes); else pass_cnt++;
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_flush();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
